// File: rtl/cmos_dvp_capture.sv
// -----------------------------------------------------------------------------
// cmos_dvp_capture
//   Captures OV5640 DVP bytes, packs byte pairs into RGB565 pixels and emits
//   them with x/y coordinates and frame/line markers toward the frame-buffer
//   write FIFO. Capture is held off until the SCCB configuration has finished
//   and a number of settling frames have passed. Frame geometry is checked,
//   and any violation sets a sticky error flag.
//
// Ports
//   cmos_pclk    in   camera pixel clock (sole clock)
//   I_rst_n      in   async active-low reset
//   I_cfg_done   in   SCCB config complete (level, synchronised here)
//   I_vsync      in   camera vsync
//   I_href       in   camera href, high = valid bytes
//   I_data[7:0]  in   camera byte
//   I_fifo_full  in   downstream FIFO full
//   I_err_clr    in   one-cycle pulse, clears sticky error flags
//   O_pix_valid  out  pixel write strobe
//   O_pix_data   out  RGB565 {first byte, second byte}
//   O_pix_x      out  pixel column
//   O_pix_y      out  line number
//   O_sof        out  strobe-aligned first pixel of frame
//   O_eol        out  strobe-aligned last pixel of line
//   O_frame_cnt  out  captured frame count (wraps)
//   O_err_line   out  sticky: bad line length or odd byte count
//   O_err_frame  out  sticky: bad line count at frame end
//   O_err_ovf    out  sticky: pixel dropped because FIFO was full
//   O_capturing  out  high while in CAPTURE
//
// FSM states
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   WAIT_CFG   | sensor not configured yet; nothing captured
//   SKIP       | counting frame ends until FRAME_SKIP settling frames pass
//   ARM        | waiting for the next frame start (never join mid-frame)
//   CAPTURE    | packing pixels of the current frame
// -----------------------------------------------------------------------------
module cmos_dvp_capture #(
  parameter int H_RES      = 1280,
  parameter int V_RES      = 720,
  parameter int FRAME_SKIP = 10,
  parameter bit VS_POL     = 1'b1
) (
  input  logic        cmos_pclk,
  input  logic        I_rst_n,
  input  logic        I_cfg_done,
  input  logic        I_vsync,
  input  logic        I_href,
  input  logic [7:0]  I_data,
  input  logic        I_fifo_full,
  input  logic        I_err_clr,
  output logic        O_pix_valid,
  output logic [15:0] O_pix_data,
  output logic [11:0] O_pix_x,
  output logic [11:0] O_pix_y,
  output logic        O_sof,
  output logic        O_eol,
  output logic [15:0] O_frame_cnt,
  output logic        O_err_line,
  output logic        O_err_frame,
  output logic        O_err_ovf,
  output logic        O_capturing
);

  localparam logic [11:0] LP_H    = 12'(H_RES);
  localparam logic [11:0] LP_V    = 12'(V_RES);
  localparam logic [11:0] LP_HM1  = 12'(H_RES - 1);
  localparam logic [7:0]  LP_SKIP = 8'(FRAME_SKIP);

  typedef enum logic [1:0] {
    ST_WAIT_CFG = 2'd0,
    ST_SKIP     = 2'd1,
    ST_ARM      = 2'd2,
    ST_CAPTURE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_vsync_s1;
  logic        r_href_s1;
  logic [7:0]  r_data_s1;
  logic        r_href_s2;
  logic        r_vs_act_d;
  logic        r_cfg_meta;
  logic        r_cfg_sync;

  logic [7:0]  r_skip_cnt;
  logic        r_phase;
  logic [7:0]  r_msb;
  logic [11:0] r_x_cnt;
  logic [11:0] r_y_cnt;

  logic        r_pix_valid;
  logic [15:0] r_pix_data;
  logic [11:0] r_pix_x;
  logic [11:0] r_pix_y;
  logic        r_sof;
  logic        r_eol;
  logic [15:0] r_frame_cnt;
  logic        r_err_line;
  logic        r_err_frame;
  logic        r_err_ovf;

  logic        w_vs_act;
  logic        w_frame_start;
  logic        w_frame_end;
  logic        w_href_fall;
  logic        w_skip_done;
  logic        w_skip_clr;
  logic        w_skip_inc;
  logic        w_frame_done;
  logic        w_in_cap;
  logic        w_pix_done;
  logic        w_pix_wr;
  logic        w_line_bad;
  logic        w_frame_bad;
  logic        w_ovf;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Input stage and event decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_vsync_s1 <= 1'b0;
      r_href_s1  <= 1'b0;
      r_data_s1  <= 8'd0;
      r_href_s2  <= 1'b0;
      r_vs_act_d <= 1'b0;
      r_cfg_meta <= 1'b0;
      r_cfg_sync <= 1'b0;
    end else begin
      r_vsync_s1 <= I_vsync;
      r_href_s1  <= I_href;
      r_data_s1  <= I_data;
      r_href_s2  <= r_href_s1;
      r_vs_act_d <= w_vs_act;
      r_cfg_meta <= I_cfg_done;
      r_cfg_sync <= r_cfg_meta;
    end
  end

  assign w_vs_act      = (r_vsync_s1 == VS_POL);
  assign w_frame_start = r_vs_act_d & ~w_vs_act;
  assign w_frame_end   = ~r_vs_act_d & w_vs_act;
  assign w_href_fall   = r_href_s2 & ~r_href_s1;

  // 9-bit compare so a counter at 255 cannot wrap into a false match
  assign w_skip_done   = ({1'b0, r_skip_cnt} + 9'd1) >= {1'b0, LP_SKIP};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) r_state <= ST_WAIT_CFG;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_skip_clr   = 1'b0;
    w_skip_inc   = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_WAIT_CFG: begin
        if (r_cfg_sync) begin
          w_skip_clr  = 1'b1;
          w_state_nxt = (LP_SKIP == 8'd0) ? ST_ARM : ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (!r_cfg_sync) begin
          w_state_nxt = ST_WAIT_CFG;
        end else if (w_frame_end) begin
          if (w_skip_done) w_state_nxt = ST_ARM;
          else             w_skip_inc  = 1'b1;
        end
      end
      ST_ARM: begin
        if (!r_cfg_sync)        w_state_nxt = ST_WAIT_CFG;
        else if (w_frame_start) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!r_cfg_sync) begin
          // partial frame is abandoned and not counted
          w_state_nxt = ST_WAIT_CFG;
        end else if (w_frame_end) begin
          w_state_nxt  = ST_ARM;
          w_frame_done = 1'b1;
        end
      end
      default: w_state_nxt = ST_WAIT_CFG;
    endcase
  end

  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n)        r_skip_cnt <= 8'd0;
    else if (w_skip_clr) r_skip_cnt <= 8'd0;
    else if (w_skip_inc) r_skip_cnt <= r_skip_cnt + 8'd1;
  end

  // ---------------------------------------------------------------------------
  // Byte packing and coordinates
  // ---------------------------------------------------------------------------
  assign w_in_cap    = (r_state == ST_CAPTURE);
  assign w_pix_done  = w_in_cap & r_href_s1 & r_phase;
  assign w_pix_wr    = w_pix_done & ~I_fifo_full;
  assign w_ovf       = w_pix_done & I_fifo_full;
  // phase is still valid on the href-fall cycle, so an odd byte count shows here
  assign w_line_bad  = w_in_cap & w_href_fall & ((r_x_cnt != LP_H) | r_phase);
  assign w_frame_bad = w_frame_done & (r_y_cnt != LP_V);

  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_phase <= 1'b0;
      r_msb   <= 8'd0;
      r_x_cnt <= 12'd0;
      r_y_cnt <= 12'd0;
    end else if (!w_in_cap) begin
      r_phase <= 1'b0;
      r_x_cnt <= 12'd0;
      r_y_cnt <= 12'd0;
    end else begin
      if (r_href_s1) begin
        r_phase <= ~r_phase;
        if (!r_phase) r_msb <= r_data_s1;
      end else begin
        r_phase <= 1'b0;
      end

      // dropped pixels still advance x so coordinates stay geometric
      if (w_pix_done)       r_x_cnt <= sat_inc(r_x_cnt);
      else if (w_href_fall) r_x_cnt <= 12'd0;

      if (w_frame_start)
        r_y_cnt <= 12'd0;
      else if (w_href_fall && (r_x_cnt != 12'd0))
        r_y_cnt <= sat_inc(r_y_cnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Output register, frame counter, sticky errors
  // ---------------------------------------------------------------------------
  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_pix_valid <= 1'b0;
      r_pix_data  <= 16'd0;
      r_pix_x     <= 12'd0;
      r_pix_y     <= 12'd0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
    end else begin
      r_pix_valid <= w_pix_wr;
      // markers are qualified by the strobe; data and coordinates are held
      r_sof       <= w_pix_wr & (r_x_cnt == 12'd0) & (r_y_cnt == 12'd0);
      r_eol       <= w_pix_wr & (r_x_cnt == LP_HM1);
      if (w_pix_wr) begin
        r_pix_data <= {r_msb, r_data_s1};
        r_pix_x    <= r_x_cnt;
        r_pix_y    <= r_y_cnt;
      end
    end
  end

  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_frame_cnt <= 16'd0;
      r_err_line  <= 1'b0;
      r_err_frame <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      // a new error in the clear cycle takes precedence
      r_err_line  <= w_line_bad  | (r_err_line  & ~I_err_clr);
      r_err_frame <= w_frame_bad | (r_err_frame & ~I_err_clr);
      r_err_ovf   <= w_ovf       | (r_err_ovf   & ~I_err_clr);
    end
  end

  assign O_pix_valid = r_pix_valid;
  assign O_pix_data  = r_pix_data;
  assign O_pix_x     = r_pix_x;
  assign O_pix_y     = r_pix_y;
  assign O_sof       = r_sof;
  assign O_eol       = r_eol;
  assign O_frame_cnt = r_frame_cnt;
  assign O_err_line  = r_err_line;
  assign O_err_frame = r_err_frame;
  assign O_err_ovf   = r_err_ovf;
  assign O_capturing = w_in_cap;

endmodule
